// File: rtl/write_status_struct_pkg.sv
// Shared types and widths for the status-struct writer.
//   CL_WIDTH  : bits per cache line
//   CL_ADDR_W : cache-line address width
//   TAG_W     : write request/response tag width
//   ss_state_t: writer FSM state
package write_status_struct_pkg;

    localparam int CL_WIDTH  = 512;
    localparam int CL_ADDR_W = 58;
    localparam int TAG_W     = 9;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND     = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_DONE     = 2'd3
    } ss_state_t;

endpackage

// File: rtl/write_status_struct.sv
// Writes an AFU status struct (up to MAX_NUM_STATUS_CL cache lines) to host
// memory at base_addr: one TX write per line, then waits for a response for
// every issued write and raises a sticky done flag.
// Ports:
//   clk, rst_n             : clock, async active-low reset
//   put_status_struct      : start pulse (honoured only in IDLE/DONE)
//   base_addr              : line address of line 0
//   status_struct_length   : requested line count (clamped to MAX_NUM_STATUS_CL)
//   afu_status_struct      : status lines, line i at [512*(i+1)-1:512*i]
//   ss_tx_wr_*             : write request channel (valid/free handshake)
//   ss_rx_wr_tag/valid     : write responses
//   status_struct_busy/done: progress flags
module write_status_struct
    import write_status_struct_pkg::*;
#(
    parameter int MAX_NUM_STATUS_CL = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  put_status_struct,
    input  logic [CL_ADDR_W-1:0]                  base_addr,
    input  logic [31:0]                           status_struct_length,
    input  logic [MAX_NUM_STATUS_CL*CL_WIDTH-1:0] afu_status_struct,
    output logic [CL_ADDR_W-1:0]                  ss_tx_wr_addr,
    output logic [TAG_W-1:0]                      ss_tx_wr_tag,
    output logic [CL_WIDTH-1:0]                   ss_tx_wr_data,
    output logic                                  ss_tx_wr_valid,
    input  logic                                  ss_tx_wr_free,
    input  logic [TAG_W-1:0]                      ss_rx_wr_tag,
    input  logic                                  ss_rx_wr_valid,
    output logic                                  status_struct_busy,
    output logic                                  status_struct_done
);

    localparam int SNAP_W = MAX_NUM_STATUS_CL * CL_WIDTH;

    ss_state_t             state_q, state_d;
    logic [SNAP_W-1:0]     snap_q, snap_d;
    logic [CL_ADDR_W-1:0]  base_q, base_d;
    logic [31:0]           num_q, num_d;
    logic [31:0]           wr_cnt_q, wr_cnt_d;
    logic [31:0]           acks_q, acks_d;
    logic [CL_ADDR_W-1:0]  addr_q, addr_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic [CL_WIDTH-1:0]   data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  start;
    logic                  ack_in;
    logic [31:0]           num_clamp;
    logic [CL_WIDTH-1:0]   line_sel;

    // Responses are counted, not matched; the tag is intentionally unused.
    logic unused_tag;
    assign unused_tag = ^ss_rx_wr_tag;

    always_comb begin
        start     = put_status_struct && (state_q == S_IDLE || state_q == S_DONE);
        ack_in    = ss_rx_wr_valid && (state_q == S_SEND || state_q == S_WAIT_ACK);
        num_clamp = (status_struct_length > 32'(MAX_NUM_STATUS_CL))
                    ? 32'(MAX_NUM_STATUS_CL) : status_struct_length;

        // wr_cnt < num_q <= MAX whenever this is used, so one match always hits.
        line_sel = '0;
        for (int i = 0; i < MAX_NUM_STATUS_CL; i++) begin
            if (wr_cnt_q == 32'(i)) line_sel = snap_q[i*CL_WIDTH +: CL_WIDTH];
        end

        state_d  = state_q;
        snap_d   = start ? afu_status_struct : snap_q;
        base_d   = base_q;
        num_d    = num_q;
        wr_cnt_d = wr_cnt_q;
        acks_d   = acks_q;
        addr_d   = addr_q;
        tag_d    = tag_q;
        data_d   = data_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = done_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    base_d   = base_addr;
                    num_d    = num_clamp;
                    wr_cnt_d = '0;
                    acks_d   = '0;
                    valid_d  = 1'b0;
                    if (num_clamp == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_SEND;
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_SEND: begin
                // Output register only moves when empty or being accepted,
                // so a stalled request is held exactly as issued.
                if (!valid_q || ss_tx_wr_free) begin
                    if (wr_cnt_q < num_q) begin
                        valid_d  = 1'b1;
                        addr_d   = base_q + CL_ADDR_W'(wr_cnt_q);
                        tag_d    = wr_cnt_q[TAG_W-1:0];
                        data_d   = line_sel;
                        wr_cnt_d = wr_cnt_q + 32'd1;
                    end else begin
                        valid_d = 1'b0;
                        state_d = S_WAIT_ACK;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (acks_q == num_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ack_in) acks_d = acks_q + 32'd1;
    end

    // Snapshot keeps its contents through reset.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            num_q    <= '0;
            wr_cnt_q <= '0;
            acks_q   <= '0;
            addr_q   <= '0;
            tag_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            num_q    <= num_d;
            wr_cnt_q <= wr_cnt_d;
            acks_q   <= acks_d;
            addr_q   <= addr_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ss_tx_wr_addr      = addr_q;
    assign ss_tx_wr_tag       = tag_q;
    assign ss_tx_wr_data      = data_q;
    assign ss_tx_wr_valid     = valid_q;
    assign status_struct_busy = busy_q;
    assign status_struct_done = done_q;

endmodule
